// File: rtl/cpu_trace_pkg.sv
// Shared types, ASCII constants and helpers for the CPU trace line emitter.
package cpu_trace_pkg;

  localparam int unsigned TIME_W     = 14;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HEX_DIGITS = 8;
  localparam int unsigned CNT_W      = 3;

  // Fixed characters per line; add time digits (and register digits for $ lines).
  localparam int unsigned LINE_REG_BASE = 26;
  localparam int unsigned LINE_MEM_BASE = 34;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_LA     = 8'h61;
  localparam logic [7:0] CH_UA     = 8'h41;

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
    S_OPND, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
    if (nib < 4'd10) return CH_ZERO + 8'(nib);
    return (upper ? CH_UA : CH_LA) + 8'(nib) - 8'd10;
  endfunction

  // Nibble i of a word counting from the most significant end.
  function automatic logic [3:0] nibble_at(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] i);
    return 4'(w >> (5'd28 - {i, 2'b00}));
  endfunction

endpackage

// File: rtl/cpu_trace_emitter_bin2bcd14.sv
// Combinational double-dabble: 14-bit binary (<= 9999) to four BCD digits and significant-digit count.
module bin2bcd14
  import cpu_trace_pkg::*;
(
  input  logic [TIME_W-1:0] bin,
  output logic [3:0][3:0]   bcd_c,
  output logic [CNT_W-1:0]  ndig_c
);

  logic [TIME_W+15:0] sh;

  always_comb begin
    sh = {16'd0, bin};
    for (int i = 0; i < int'(TIME_W); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[TIME_W+4*d +: 4] >= 4'd5) sh[TIME_W+4*d +: 4] = sh[TIME_W+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    bcd_c = sh[TIME_W+15:TIME_W];
  end

  always_comb begin
    ndig_c = 3'd1;
    if (bcd_c[3] != 4'd0)      ndig_c = 3'd4;
    else if (bcd_c[2] != 4'd0) ndig_c = 3'd3;
    else if (bcd_c[1] != 4'd0) ndig_c = 3'd2;
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes one write-back record per request into an ASCII trace line, one character per clock.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter bit          UPPER_HEX = 1'b0,
  parameter int unsigned TIME_MAX  = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kind,
  input  logic [TIME_W-1:0] time_in,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [REG_W-1:0]  reg_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] data_in,
  output logic [7:0]        char,
  output logic              valid,
  output logic              ready,
  output logic              done
);

  state_e             state, state_nx;
  logic [CNT_W-1:0]   idx, idx_nx;
  logic               kind_q;
  logic [TIME_W-1:0]  time_q;
  logic [WORD_W-1:0]  pc_q, addr_q, data_q;
  logic [REG_W-1:0]   reg_q;
  logic [CNT_W-1:0]   td_q, rd_q;

  logic               accept_c;
  logic [TIME_W-1:0]  time_clamp_c, conv_in_c;
  logic [3:0][3:0]    tbcd_c;
  logic [CNT_W-1:0]   tdig_c;
  logic [1:0]         tpos_c;
  logic [3:0]         reg_tens_c, reg_ones_c;
  logic [7:0]         char_nx;

  assign accept_c     = start && ready;
  assign time_clamp_c = (time_in > TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : time_in;

  // Digits are never needed in the accept cycle (next char is '^'), so the
  // converter is borrowed then to size the incoming time field.
  assign conv_in_c = accept_c ? time_clamp_c : time_q;

  bin2bcd14 u_bin2bcd14 (
    .bin    (conv_in_c),
    .bcd_c  (tbcd_c),
    .ndig_c (tdig_c)
  );

  always_comb begin
    reg_tens_c = 4'd0;
    if (reg_q >= 5'd30)      reg_tens_c = 4'd3;
    else if (reg_q >= 5'd20) reg_tens_c = 4'd2;
    else if (reg_q >= 5'd10) reg_tens_c = 4'd1;
    reg_ones_c = 4'(reg_q - 5'(reg_tens_c) * 5'd10);
  end

  // Next state and digit index; idx restarts at 0 whenever a field ends.
  always_comb begin
    state_nx = state;
    idx_nx   = '0;
    case (state)
      S_IDLE:  if (accept_c) state_nx = S_CARET;
      S_CARET: state_nx = S_TIME;
      S_TIME:  if (idx == 3'(td_q - 3'd1)) state_nx = S_AT;
               else idx_nx = idx + 3'd1;
      S_AT:    state_nx = S_PC;
      S_PC:    if (idx == 3'(HEX_DIGITS - 1)) state_nx = S_COLON;
               else idx_nx = idx + 3'd1;
      S_COLON: state_nx = S_SP1;
      S_SP1:   state_nx = S_SIGIL;
      S_SIGIL: state_nx = S_OPND;
      S_OPND:  if (idx == (kind_q ? 3'(HEX_DIGITS - 1) : 3'(rd_q - 3'd1))) state_nx = S_SP2;
               else idx_nx = idx + 3'd1;
      S_SP2:   state_nx = S_LT;
      S_LT:    state_nx = S_EQ;
      S_EQ:    state_nx = S_SP3;
      S_SP3:   state_nx = S_DATA;
      S_DATA:  if (idx == 3'(HEX_DIGITS - 1)) state_nx = S_HASH;
               else idx_nx = idx + 3'd1;
      S_HASH:  state_nx = accept_c ? S_CARET : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Character shown in the state being entered.
  always_comb begin
    char_nx = 8'h00;
    tpos_c  = 2'(td_q - 3'd1 - idx_nx);
    case (state_nx)
      S_CARET: char_nx = CH_CARET;
      S_TIME:  char_nx = CH_ZERO + 8'(tbcd_c[tpos_c]);
      S_AT:    char_nx = CH_AT;
      S_PC:    char_nx = nibble_to_ascii(nibble_at(pc_q, idx_nx), UPPER_HEX);
      S_COLON: char_nx = CH_COLON;
      S_SP1, S_SP2, S_SP3: char_nx = CH_SPACE;
      S_SIGIL: char_nx = kind_q ? CH_STAR : CH_DOLLAR;
      S_OPND:  begin
        if (kind_q) char_nx = nibble_to_ascii(nibble_at(addr_q, idx_nx), UPPER_HEX);
        else if (rd_q == 3'd2 && idx_nx == 3'd0) char_nx = CH_ZERO + 8'(reg_tens_c);
        else char_nx = CH_ZERO + 8'(reg_ones_c);
      end
      S_LT:    char_nx = CH_LT;
      S_EQ:    char_nx = CH_EQ;
      S_DATA:  char_nx = nibble_to_ascii(nibble_at(data_q, idx_nx), UPPER_HEX);
      S_HASH:  char_nx = CH_HASH;
      default: char_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      char   <= 8'h00;
      valid  <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      kind_q <= 1'b0;
      time_q <= '0;
      pc_q   <= '0;
      reg_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      td_q   <= 3'd1;
      rd_q   <= 3'd1;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      char  <= char_nx;
      valid <= (state_nx != S_IDLE);
      ready <= (state_nx == S_IDLE) || (state_nx == S_HASH);
      done  <= (state_nx == S_HASH);
      if (accept_c) begin
        kind_q <= kind;
        time_q <= time_clamp_c;
        pc_q   <= pc_in;
        reg_q  <= reg_in;
        addr_q <= addr_in;
        data_q <= data_in;
        td_q   <= tdig_c;
        rd_q   <= (reg_in >= 5'd10) ? 3'd2 : 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench: a string-formatting reference model feeds expected characters to a per-DUT monitor.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kind = 1'b0;
  logic [13:0] time_in = '0;
  logic [31:0] pc_in = '0;
  logic [4:0]  reg_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;

  logic [7:0]  char_lo, char_up;
  logic        valid_lo, ready_lo, done_lo;
  logic        valid_up, ready_up, done_up;

  cpu_trace_emitter #(.UPPER_HEX(1'b0), .TIME_MAX(9999)) u_dut (
    .clk(clk), .reset(reset), .start(start), .kind(kind), .time_in(time_in),
    .pc_in(pc_in), .reg_in(reg_in), .addr_in(addr_in), .data_in(data_in),
    .char(char_lo), .valid(valid_lo), .ready(ready_lo), .done(done_lo));

  cpu_trace_emitter #(.UPPER_HEX(1'b1), .TIME_MAX(9999)) u_dut_up (
    .clk(clk), .reset(reset), .start(start), .kind(kind), .time_in(time_in),
    .pc_in(pc_in), .reg_in(reg_in), .addr_in(addr_in), .data_in(data_in),
    .char(char_up), .valid(valid_up), .ready(ready_up), .done(done_up));

  always #5 clk = ~clk;

  logic [7:0] q_lo[$];
  logic [7:0] q_up[$];
  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  function automatic string line_of(bit up, bit k, int t, logic [31:0] pc, int r,
                                    logic [31:0] a, logic [31:0] d);
    string spc, sop, sdat;
    int tc;
    tc   = (t > 9999) ? 9999 : t;
    spc  = $sformatf("%08h", pc);
    sdat = $sformatf("%08h", d);
    sop  = k ? $sformatf("*%08h", a) : $sformatf("$%0d", r);
    if (up) begin
      spc  = spc.toupper();
      sdat = sdat.toupper();
      sop  = sop.toupper();
    end
    return $sformatf("^%0d@%s: %s <= %s#", tc, spc, sop, sdat);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference: a line is accepted when start is high and no earlier line is still pending.
  always @(posedge clk) begin
    string s_lo, s_up;
    if (reset) begin
      q_lo.delete();
      q_up.delete();
    end else if (start && q_lo.size() == 0) begin
      s_lo = line_of(1'b0, kind, int'(time_in), pc_in, int'(reg_in), addr_in, data_in);
      s_up = line_of(1'b1, kind, int'(time_in), pc_in, int'(reg_in), addr_in, data_in);
      for (int i = 0; i < s_lo.len(); i++) q_lo.push_back(8'(s_lo[i]));
      for (int i = 0; i < s_up.len(); i++) q_up.push_back(8'(s_up[i]));
      acc_cnt++;
    end
  end

  task automatic mon_one(int id, logic [7:0] c, logic v, logic r, logic d);
    logic [7:0] e;
    int sz;
    sz = (id != 0) ? q_up.size() : q_lo.size();
    e  = 8'h00;
    if (sz > 0) e = (id != 0) ? q_up.pop_front() : q_lo.pop_front();
    check($sformatf("char[dut%0d]", id), 32'(c), 32'(e));
    check($sformatf("valid[dut%0d]", id), 32'(v), 32'(sz > 0));
    check($sformatf("ready[dut%0d]", id), 32'(r), 32'(sz <= 1));
    check($sformatf("done[dut%0d]", id), 32'(d), 32'(sz == 1));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_one(0, char_lo, valid_lo, ready_lo, done_lo);
      mon_one(1, char_up, valid_up, ready_up, done_up);
    end
  end

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a record and hold start until accepted; scramble inputs afterwards unless holding.
  task automatic send(bit k, int t, logic [31:0] pc, int r, logic [31:0] a, logic [31:0] d, bit hold);
    int c0, waited;
    c0 = acc_cnt;
    waited = 0;
    kind = k; time_in = 14'(t); pc_in = pc; reg_in = 5'(r); addr_in = a; data_in = d;
    start = 1'b1;
    while (acc_cnt == c0 && waited < 200) begin
      step(1);
      waited++;
    end
    if (acc_cnt == c0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: no accept after %0d cycles, required within 200", waited);
    end
    if (!hold) begin
      start = 1'b0;
      kind = 1'($urandom); time_in = 14'($urandom); pc_in = $urandom;
      reg_in = 5'($urandom); addr_in = $urandom; data_in = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q_lo.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    if (q_lo.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: %0d chars pending, required 0", q_lo.size());
    end
  endtask

  initial begin
    int t;
    bit k, h;
    step(5);
    reset = 1'b0;
    step(2);

    send(1'b0, 242, 32'h00030f44, 31, 32'h0, 32'h12345678, 1'b0);
    wait_idle();
    send(1'b1, 338, 32'h00003130, 0, 32'h00000088, 32'hfffb52b0, 1'b0);
    wait_idle();
    send(1'b0, 0, 32'h0000abcd, 0, 32'h0, 32'h00000000, 1'b0);
    send(1'b0, 12000, 32'hdeadbeef, 9, 32'h0, 32'hcafef00d, 1'b0);
    send(1'b0, 9999, 32'h00000001, 10, 32'h0, 32'h0000000f, 1'b0);
    send(1'b1, 16383, 32'h80000000, 3, 32'hffffffff, 32'h0a0b0c0d, 1'b0);
    wait_idle();

    // Back-to-back with start held, then a stray start pulse mid-line.
    send(1'b0, 1000, 32'h11111111, 20, 32'h0, 32'h22222222, 1'b1);
    send(1'b1, 99, 32'h33333333, 0, 32'h44444444, 32'h55555555, 1'b1);
    send(1'b0, 7, 32'h66666666, 5, 32'h0, 32'h77777777, 1'b0);
    step(6);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle();

    // Reset while the fourth PC digit is on the output.
    send(1'b0, 242, 32'h00030f44, 31, 32'h0, 32'h12345678, 1'b0);
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    send(1'b1, 55, 32'h0badc0de, 0, 32'h00001234, 32'h9abcdef0, 1'b0);
    wait_idle();

    for (int n = 0; n < 50; n++) begin
      k = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       t = 0;
        1:       t = 9999;
        2:       t = $urandom_range(10000, 16383);
        default: t = $urandom_range(0, 9998);
      endcase
      h = ($urandom_range(0, 2) == 0) && (n != 49);
      send(k, t, $urandom, $urandom_range(0, 31), $urandom, $urandom, h);
      if (!h && $urandom_range(0, 3) == 0) begin
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
      end
      if (!h && $urandom_range(0, 3) == 0) step($urandom_range(1, 40));
    end
    start = 1'b0;
    wait_idle();
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
Name: cpu_trace_emitter

Overview:
- Serializes one CPU write-back record per request into the ASCII trace line format that cpu_checker parses, one character per clock.
- Canonical register form: "^<time>@<pc>: $<reg> <= <data>#".
- Canonical memory form: "^<time>@<pc>: *<addr> <= <data>#".
- Sits at the trace output of the CPU model and drives cpu_checker's char input in self-checking benches.

Parameters:
- UPPER_HEX, 0, 1 = hex digits a-f emitted uppercase, 0 = lowercase.
- TIME_MAX, 9999, saturation value for time; must fit 4 decimal digits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted when start && ready.
- kind  input  1  0 = register write, 1 = memory write.
- time_in  input  14  cycle stamp, unsigned decimal.
- pc_in  input  32  PC, 8 hex digits.
- reg_in  input  5  register number, decimal.
- addr_in  input  32  memory address, 8 hex digits.
- data_in  input  32  written value, 8 hex digits.
- char  output  8  ASCII character; 8'h00 when not valid.
- valid  output  1  char holds a line character this cycle.
- ready  output  1  can accept start this cycle.
- done  output  1  one-cycle pulse coincident with '#'.

Behaviour:
- Reset (synchronous, active-high): char=8'h00, valid=0, ready=1, done=0; FSM to IDLE; latched fields and counters cleared. Applies mid-line: the next cycle after reset is idle and no further characters of the aborted line appear.
- Accept: on start && ready, latch kind/time_in/pc_in/reg_in/addr_in/data_in. Inputs are don't-care afterwards.
- Latency: '^' appears the cycle after acceptance, then one character per cycle with no gaps.
- FSM states: IDLE -> CARET -> TIME -> AT -> PC -> COLON -> SP1 -> SIGIL -> OPND -> SP2 -> LT -> EQ -> SP3 -> DATA -> HASH -> IDLE (or CARET on back-to-back).
- Digit counter drives TIME, PC, OPND, DATA.
- time: values above TIME_MAX clamp to TIME_MAX. Printed in decimal, most significant digit first, leading zeros suppressed, minimum one digit (0 -> "0").
- SIGIL: '$' for kind=0, '*' for kind=1.
- OPND, kind=0: reg decimal, leading zeros suppressed (0 -> "0", 31 -> "31").
- OPND, kind=1: addr as exactly 8 hex digits, MSB nibble first, zero-padded.
- pc and data: exactly 8 hex digits, zero-padded, case per UPPER_HEX.
- Line length: 26 + Td + Rd for register lines, 34 + Td for memory lines (Td/Rd = digit counts).
- ready: 1 in IDLE and in the HASH cycle, 0 otherwise. start is ignored while ready=0.
- Back-to-back: start accepted in the HASH cycle produces '^' in the very next cycle.
- done=1 only in the HASH cycle.
- valid=1 exactly in non-IDLE states.
- Decimal conversion is combinational on the latched value (sub-module). Digit count is computed at latch time.

Decomposition:
- Package cpu_trace_pkg: FSM state enum; ASCII constants ('^','@',':',' ','$','*','<','=','#','0','a'/'A'); line-length constants.
- Sub-module bin2bcd14: combinational double-dabble, 14-bit binary -> four BCD digits plus significant-digit count (1-4).
- Shared nibble-to-ASCII function lives in the package.

Test Plan:
- Register line: reset 5 cycles, then start kind=0 time=242 pc=32'h00030f44 reg=31 data=32'h12345678 -> exactly "^242@00030f44: $31 <= 12345678#" over 31 consecutive valid cycles, '^' one cycle after accept, done with '#'.
- Memory line: kind=1 time=338 pc=32'h00003130 addr=32'h00000088 data=32'hfffb52b0 -> "^338@00003130: *00000088 <= fffb52b0#" (37 chars). With UPPER_HEX=1 the data field is "FFFB52B0".
- Boundaries: time=0 reg=0 -> "^0@...: $0 <= ...#"; time=12000 -> time field "9999".
- Back-to-back and busy: start held high for two lines -> second '^' in cycle immediately after first '#'. A start pulse mid-line is ignored and the line is unchanged.
- Reset mid-line: assert reset during PC digit 3 -> next cycle char=8'h00, valid=0, ready=1. A following start emits a complete fresh line.
- Loopback: emitter char into cpu_checker -> format_type=1 after register lines, 2 after memory lines, for 50 random records.
